wb_ipi_mailbox: RTL

WB_IPI_MAILBOX -- requirements
Module: wb_ipi_mailbox

---
 rtl/wb_ipi_pkg.sv | 31 +++
 rtl/ipi_fifo.sv | 67 ++++++
 rtl/wb_ipi_mailbox.sv | 207 ++++++++++++++++++++
 3 files changed

// File: rtl/wb_ipi_pkg.sv
// Shared constants for the Wishbone inter-processor mailbox:
// register indices, STATUS/CTRL bit positions and the data width.
package wb_ipi_pkg;

    localparam int DATA_W = 32;

    // Register indices as decoded from wb_adr_i[4:2]
    localparam logic [2:0] IDX_SEND0  = 3'd0;
    localparam logic [2:0] IDX_SEND1  = 3'd1;
    localparam logic [2:0] IDX_RECV0  = 3'd2;
    localparam logic [2:0] IDX_RECV1  = 3'd3;
    localparam logic [2:0] IDX_STATUS = 3'd4;
    localparam logic [2:0] IDX_CTRL   = 3'd5;

    // STATUS layout
    localparam int ST_CNT0_LSB = 0;
    localparam int ST_CNT1_LSB = 4;
    localparam int ST_CNT_W    = 4;
    localparam int ST_OVF0_BIT = 8;
    localparam int ST_OVF1_BIT = 9;

    // CTRL layout
    localparam int CTRL_IEN_LSB  = 0;
    localparam int CTRL_IEN_W    = 2;
    localparam int CTRL_CLR0_BIT = 8;
    localparam int CTRL_CLR1_BIT = 9;

    // Full-word byte select required for SENDn writes
    localparam logic [3:0] SEL_FULL = 4'hF;

endpackage

// File: rtl/ipi_fifo.sv
// Small synchronous FIFO used as one inbound message queue.
// Push while full and pop while empty are ignored; the caller handles
// the overflow flag. Pointers wrap modulo the depth; storage is not reset.
module ipi_fifo #(
    parameter int DEPTH_LOG2 = 2,
    parameter int WIDTH      = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  push,
    input  logic                  pop,
    input  logic [WIDTH-1:0]      push_data,
    output logic [WIDTH-1:0]      head_data,
    output logic                  full,
    output logic                  empty,
    output logic [DEPTH_LOG2:0]   count
);

    localparam int                  DEPTH     = 1 << DEPTH_LOG2;
    localparam int                  CNT_W     = DEPTH_LOG2 + 1;
    localparam logic [CNT_W-1:0]    DEPTH_CNT = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0]    CNT_ONE   = CNT_W'(1);
    localparam logic [DEPTH_LOG2-1:0] PTR_ONE = DEPTH_LOG2'(1);

    logic [WIDTH-1:0]      mem_r [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr_r;
    logic [DEPTH_LOG2-1:0] rd_ptr_r;
    logic [CNT_W-1:0]      count_r;
    logic                  do_push_s;
    logic                  do_pop_s;

    assign full      = (count_r == DEPTH_CNT);
    assign empty     = (count_r == {CNT_W{1'b0}});
    assign count     = count_r;
    assign head_data = mem_r[rd_ptr_r];
    assign do_push_s = push & ~full;
    assign do_pop_s  = pop & ~empty;

    // Message storage: written on an accepted push, deliberately not reset
    always_ff @(posedge clk) begin
        if (do_push_s) begin
            mem_r[wr_ptr_r] <= push_data;
        end
    end

    // Pointer and occupancy bookkeeping
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_r <= {DEPTH_LOG2{1'b0}};
            rd_ptr_r <= {DEPTH_LOG2{1'b0}};
            count_r  <= {CNT_W{1'b0}};
        end else begin
            if (do_push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_ONE;
            end
            if (do_pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
            case ({do_push_s, do_pop_s})
                2'b10:   count_r <= count_r + CNT_ONE;
                2'b01:   count_r <= count_r - CNT_ONE;
                default: count_r <= count_r;
            endcase
        end
    end

endmodule

// File: rtl/wb_ipi_mailbox.sv
// Wishbone B3 slave providing a two-core inter-processor mailbox:
// one inbound queue per core, a STATUS/CTRL pair and a level interrupt
// per core. Every access terminates with a single-cycle ack or err on
// the edge after it is accepted; bursts are treated as classic singles.
// Only NUM_CORES == 2 is supported.
module wb_ipi_mailbox
    import wb_ipi_pkg::*;
#(
    parameter int DEPTH_LOG2 = 2,
    parameter int NUM_CORES  = 2
) (
    input  logic                  wb_clk_i,
    input  logic                  wb_rst_i,
    input  logic [31:0]           wb_adr_i,
    input  logic [31:0]           wb_dat_i,
    input  logic [3:0]            wb_sel_i,
    input  logic                  wb_we_i,
    input  logic                  wb_cyc_i,
    input  logic                  wb_stb_i,
    input  logic [2:0]            wb_cti_i,
    input  logic [1:0]            wb_bte_i,
    output logic [31:0]           wb_dat_o,
    output logic                  wb_ack_o,
    output logic                  wb_err_o,
    output logic                  wb_rty_o,
    output logic [NUM_CORES-1:0]  irq_o
);

    logic                   ack_r;
    logic                   err_r;
    logic [DATA_W-1:0]      dat_r;
    logic [NUM_CORES-1:0]   irq_r;
    logic [1:0]             ien_r;
    logic [1:0]             ovf_r;
    logic [1:0]             ovf_nxt_s;
    logic [1:0]             clr_s;

    logic                   accept_s;
    logic [2:0]             idx_s;
    logic                   dec_err_s;
    logic [DATA_W-1:0]      rd_data_s;
    logic [1:0]             push_req_s;
    logic [1:0]             pop_req_s;
    logic [1:0]             push_s;
    logic [1:0]             pop_s;
    logic                   ctrl_wr_s;
    logic [DATA_W-1:0]      status_s;
    logic [DATA_W-1:0]      ctrl_rd_s;

    logic [DATA_W-1:0]      head_s  [2];
    logic [DEPTH_LOG2:0]    count_s [2];
    logic [1:0]             full_s;
    logic [1:0]             empty_s;
    logic [1:0]             busy_s;

    // Bus signals that carry no meaning for this slave
    logic unused_s;
    assign unused_s = ^{wb_cti_i, wb_bte_i, wb_adr_i[31:5], wb_adr_i[1:0]};

    assign accept_s = wb_cyc_i & wb_stb_i & ~ack_r & ~err_r;
    assign idx_s    = wb_adr_i[4:2];
    assign push_s   = push_req_s & {2{accept_s}};
    assign pop_s    = pop_req_s & {2{accept_s}};
    assign busy_s   = ~empty_s;

    assign wb_ack_o = ack_r;
    assign wb_err_o = err_r;
    assign wb_dat_o = dat_r;
    assign wb_rty_o = 1'b0;
    assign irq_o    = irq_r;

    // One inbound queue per core
    for (genvar n = 0; n < 2; n++) begin : g_queue
        ipi_fifo #(
            .DEPTH_LOG2 (DEPTH_LOG2),
            .WIDTH      (DATA_W)
        ) u_fifo (
            .clk        (wb_clk_i),
            .rst        (wb_rst_i),
            .push       (push_s[n]),
            .pop        (pop_s[n]),
            .push_data  (wb_dat_i),
            .head_data  (head_s[n]),
            .full       (full_s[n]),
            .empty      (empty_s[n]),
            .count      (count_s[n])
        );
    end

    // Assemble the STATUS and CTRL read views
    always_comb begin
        status_s = 32'h0;
        status_s[ST_CNT0_LSB +: ST_CNT_W] = 4'(count_s[0]);
        status_s[ST_CNT1_LSB +: ST_CNT_W] = 4'(count_s[1]);
        status_s[ST_OVF0_BIT] = ovf_r[0];
        status_s[ST_OVF1_BIT] = ovf_r[1];
        ctrl_rd_s = 32'h0;
        ctrl_rd_s[CTRL_IEN_LSB +: CTRL_IEN_W] = ien_r;
    end

    // Decode the addressed register into error, read data and side-effect requests
    always_comb begin
        dec_err_s  = 1'b0;
        rd_data_s  = 32'h0;
        push_req_s = 2'b00;
        pop_req_s  = 2'b00;
        ctrl_wr_s  = 1'b0;
        case (idx_s)
            IDX_SEND0, IDX_SEND1: begin
                if (wb_we_i && (wb_sel_i == SEL_FULL)) begin
                    push_req_s[idx_s[0]] = 1'b1;
                end else begin
                    dec_err_s = 1'b1;
                end
            end
            IDX_RECV0, IDX_RECV1: begin
                if (wb_we_i) begin
                    dec_err_s = 1'b1;
                end else begin
                    pop_req_s[idx_s[0]] = 1'b1;
                    // An empty queue reads as zero rather than stale storage
                    if (empty_s[idx_s[0]]) begin
                        rd_data_s = 32'h0;
                    end else begin
                        rd_data_s = head_s[idx_s[0]];
                    end
                end
            end
            IDX_STATUS: begin
                if (wb_we_i) begin
                    dec_err_s = 1'b1;
                end else begin
                    rd_data_s = status_s;
                end
            end
            IDX_CTRL: begin
                if (wb_we_i) begin
                    ctrl_wr_s = 1'b1;
                end else begin
                    rd_data_s = ctrl_rd_s;
                end
            end
            default: begin
                dec_err_s = 1'b1;
            end
        endcase
    end

    // Overflow flags: a push into a full queue sets, a CTRL write-1 clears, set wins
    always_comb begin
        ovf_nxt_s = ovf_r;
        if (accept_s && ctrl_wr_s && wb_sel_i[1]) begin
            clr_s = wb_dat_i[CTRL_CLR1_BIT:CTRL_CLR0_BIT];
        end else begin
            clr_s = 2'b00;
        end
        for (int n = 0; n < 2; n++) begin
            if (push_s[n] && full_s[n]) begin
                ovf_nxt_s[n] = 1'b1;
            end else if (clr_s[n]) begin
                ovf_nxt_s[n] = 1'b0;
            end else begin
                ovf_nxt_s[n] = ovf_r[n];
            end
        end
    end

    // Bus termination and registered read data, one cycle after acceptance
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            ack_r <= 1'b0;
            err_r <= 1'b0;
            dat_r <= 32'h0;
        end else if (accept_s) begin
            ack_r <= ~dec_err_s;
            err_r <= dec_err_s;
            dat_r <= dec_err_s ? 32'h0 : rd_data_s;
        end else begin
            ack_r <= 1'b0;
            err_r <= 1'b0;
            dat_r <= 32'h0;
        end
    end

    // Interrupt enables and overflow flags
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            ien_r <= 2'b00;
            ovf_r <= 2'b00;
        end else begin
            if (accept_s && ctrl_wr_s && wb_sel_i[0]) begin
                ien_r <= wb_dat_i[CTRL_IEN_LSB +: CTRL_IEN_W];
            end
            ovf_r <= ovf_nxt_s;
        end
    end

    // Per-core interrupt from the settled enable and occupancy state
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            irq_r <= {NUM_CORES{1'b0}};
        end else begin
            irq_r <= ien_r & busy_s;
        end
    end

endmodule
